// File: rtl/ov7670_tx.sv
// ov7670_tx: OV7670-style camera transmitter driving PCLK/VSYNC/HREF/byte bus.
// Ports: i_clk, i_n_reset (async, active-low); i_start, i_continuous frame
// control; i_pixel/o_pix_req RGB565 pixel fetch; o_PCLK, o_VS, o_HS, o_DATA
// camera bus; o_busy, o_frame_done status.
// Macro OV7670_TX_TESTPATTERN_EN: pixel = {h[4:0], v[5:0], ~h[4:0]}, i_pixel
// ignored and o_pix_req held low.
module ov7670_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int H_WIDTH    = 320,
  parameter int V_WIDTH    = 240,
  parameter int PCLK_HALF  = 2,
  parameter int H_BLANK    = 16,
  parameter int VS_LINES   = 3,
  parameter int V_BACK     = 2,
  parameter int V_FRONT    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_n_reset,
  input  logic                  i_start,
  input  logic                  i_continuous,
  input  logic [15:0]           i_pixel,
  output logic                  o_pix_req,
  output logic                  o_PCLK,
  output logic                  o_VS,
  output logic                  o_HS,
  output logic [DATA_WIDTH-1:0] o_DATA,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam int L    = 2 * H_WIDTH + H_BLANK;
  localparam int HW   = (H_WIDTH > 1) ? $clog2(H_WIDTH) : 1;
  localparam int VW   = (V_WIDTH > 1) ? $clog2(V_WIDTH) : 1;
  localparam int CW   = (L > 1) ? $clog2(L) : 1;
  localparam int PW   = (PCLK_HALF > 1) ? $clog2(PCLK_HALF) : 1;
  localparam int LM1  = (VS_LINES > V_BACK) ? VS_LINES : V_BACK;
  localparam int LMAX = (LM1 > V_FRONT) ? LM1 : V_FRONT;
  localparam int LW   = (LMAX > 1) ? $clog2(LMAX) : 1;

  typedef enum logic [2:0] {
    IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT
  } state_t;

  state_t         state;
  logic [PW-1:0]  pcnt;
  logic [CW-1:0]  col;
  logic [LW-1:0]  lcnt;
  logic [HW-1:0]  h;
  logic [VW-1:0]  v;
  logic           start_q;

  logic tog, fall, last_col, last_v;
  logic line_end, frame_end;

  assign tog      = (pcnt == PW'(PCLK_HALF - 1));
  assign fall     = tog & o_PCLK;
  assign last_col = (col == CW'(L - 1));
  assign last_v   = (v == VW'(V_WIDTH - 1));
  // With H_BLANK=0 the last odd byte of ACTIVE is also the line end.
  assign line_end = last_col &&
                    (state == HBLANK || state == ACTIVE);
  assign frame_end =
    (last_col && state == VFRONT && lcnt == LW'(V_FRONT - 1)) ||
    (line_end && last_v && V_FRONT == 0);

`ifdef OV7670_TX_TESTPATTERN_EN
  function automatic logic [15:0] px(input logic [HW-1:0] hh,
                                     input logic [VW-1:0] vv);
    logic [4:0] h5;
    h5 = 5'(hh);
    return {h5, 6'(vv), ~h5};
  endfunction

  logic unused_pixel;
  assign unused_pixel = ^i_pixel;
  assign o_pix_req    = 1'b0;
`else
  logic [15:0] pix;
  logic        nxt_act, fetch;

  function automatic logic [15:0] px(input logic [HW-1:0] hh,
                                     input logic [VW-1:0] vv);
    logic [HW+VW-1:0] unused_hv;
    unused_hv = {hh, vv};
    return pix;
  endfunction

  // Next line will be an active one: first pixel must be prefetched
  // one PCLK before the line starts.
  always_comb begin
    nxt_act = 1'b0;
    unique case (state)
      VSYNC:  nxt_act = (V_BACK == 0) &&
                        (lcnt == LW'(VS_LINES - 1));
      VBACK:  nxt_act = (lcnt == LW'(V_BACK - 1));
      ACTIVE,
      HBLANK: nxt_act = !last_v;
      default: nxt_act = 1'b0;
    endcase
  end

  assign fetch =
    (state == ACTIVE && !col[0] && h != HW'(H_WIDTH - 1)) ||
    (col == CW'(L - 2) && nxt_act);
`endif

  function automatic logic [DATA_WIDTH-1:0] hi(input logic [15:0] p);
    return DATA_WIDTH'(p[15:8]);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lo(input logic [15:0] p);
    return DATA_WIDTH'(p[7:0]);
  endfunction

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      state        <= IDLE;
      pcnt         <= '0;
      col          <= '0;
      lcnt         <= '0;
      h            <= '0;
      v            <= '0;
      start_q      <= 1'b0;
      o_PCLK       <= 1'b0;
      o_VS         <= 1'b0;
      o_HS         <= 1'b0;
      o_DATA       <= '0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
`ifndef OV7670_TX_TESTPATTERN_EN
      o_pix_req    <= 1'b0;
      pix          <= '0;
`endif
    end else begin
      o_frame_done <= 1'b0;
      if (tog) begin
        pcnt   <= '0;
        o_PCLK <= !o_PCLK;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
      if (state == IDLE && i_start) start_q <= 1'b1;
`ifndef OV7670_TX_TESTPATTERN_EN
      o_pix_req <= fall && fetch;
      if (o_pix_req) pix <= i_pixel;
`endif
      if (fall) begin
        col <= last_col ? '0 : col + 1'b1;
        unique case (state)
          IDLE: if (start_q || i_start) begin
            state   <= VSYNC;
            start_q <= 1'b0;
            o_busy  <= 1'b1;
            o_VS    <= 1'b1;
            col     <= '0;
            lcnt    <= '0;
            h       <= '0;
            v       <= '0;
          end
          VSYNC: if (last_col) begin
            if (lcnt == LW'(VS_LINES - 1)) begin
              lcnt <= '0;
              o_VS <= 1'b0;
              if (V_BACK == 0) begin
                state  <= ACTIVE;
                o_HS   <= 1'b1;
                o_DATA <= hi(px(h, v));
              end else begin
                state <= VBACK;
              end
            end else begin
              lcnt <= lcnt + 1'b1;
            end
          end
          VBACK: if (last_col) begin
            if (lcnt == LW'(V_BACK - 1)) begin
              lcnt   <= '0;
              state  <= ACTIVE;
              o_HS   <= 1'b1;
              o_DATA <= hi(px(h, v));
            end else begin
              lcnt <= lcnt + 1'b1;
            end
          end
          ACTIVE: begin
            if (!col[0]) begin
              o_DATA <= lo(px(h, v));
            end else if (h != HW'(H_WIDTH - 1)) begin
              h      <= h + 1'b1;
              o_DATA <= hi(px(h + 1'b1, v));
            end else if (H_BLANK != 0) begin
              state  <= HBLANK;
              o_HS   <= 1'b0;
              o_DATA <= '0;
            end
          end
          HBLANK: ;
          VFRONT:
            if (last_col && lcnt != LW'(V_FRONT - 1))
              lcnt <= lcnt + 1'b1;
          default: ;
        endcase
        if (line_end) begin
          h <= '0;
          if (!last_v) begin
            v      <= v + 1'b1;
            state  <= ACTIVE;
            o_HS   <= 1'b1;
            o_DATA <= hi(px('0, v + 1'b1));
          end else if (V_FRONT != 0) begin
            state  <= VFRONT;
            lcnt   <= '0;
            o_HS   <= 1'b0;
            o_DATA <= '0;
          end
        end
        if (frame_end) begin
          o_frame_done <= 1'b1;
          o_HS         <= 1'b0;
          o_DATA       <= '0;
          h            <= '0;
          v            <= '0;
          lcnt         <= '0;
          if (i_continuous) begin
            state <= VSYNC;
            o_VS  <= 1'b1;
          end else begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_tx.sv
// tb_ov7670_tx: directed bench for ov7670_tx (small 4x3 frame).
// Covers reset, single frame, continuous stream, reset mid-line.
`timescale 1ns/1ps
module tb_ov7670_tx;

  localparam int DW = 8;
`ifdef OV7670_TX_TESTPATTERN_EN
  localparam int REQS = 0;
`else
  localparam int REQS = 12;
`endif

  logic          i_clk = 1'b0;
  logic          i_n_reset = 1'b0;
  logic          i_start = 1'b0;
  logic          i_continuous = 1'b0;
  logic [15:0]   i_pixel = 16'h0;
  logic          o_pix_req, o_PCLK, o_VS, o_HS;
  logic          o_busy, o_frame_done;
  logic [DW-1:0] o_DATA;

  int checks = 0;
  int errors = 0;

  ov7670_tx #(
    .DATA_WIDTH(DW), .H_WIDTH(4), .V_WIDTH(3),
    .PCLK_HALF(2), .H_BLANK(4), .VS_LINES(1),
    .V_BACK(1), .V_FRONT(1)
  ) dut (
    .i_clk(i_clk), .i_n_reset(i_n_reset),
    .i_start(i_start), .i_continuous(i_continuous),
    .i_pixel(i_pixel), .o_pix_req(o_pix_req),
    .o_PCLK(o_PCLK), .o_VS(o_VS), .o_HS(o_HS),
    .o_DATA(o_DATA), .o_busy(o_busy),
    .o_frame_done(o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  // monitor state
  int         cyc = 0;
  int         vlen = 0, hlen = 0, blank_bad = 0;
  logic       prev_vs = 1'b0, prev_pclk = 1'b0;
  int         vs_rise_cyc[$];
  int         vs_len[$];
  int         href_len[$];
  int         done_cyc[$];
  logic [7:0] bytes[$];
  int         req_cnt = 0, drv_mode = 0, drv_k = 0;

  function automatic logic [15:0] seq(input int k);
    return {8'(16 + k), 8'(240 - k)};
  endfunction

  function automatic logic [15:0] pat(input int hh, input int vv);
    logic [4:0] h5;
    h5 = 5'(hh);
    return {h5, 6'(vv), ~h5};
  endfunction

  function automatic logic [7:0] exp_b(input int mode, input int j);
    int f, ln, hh;
    logic [15:0] p;
    f  = j / 24;
    ln = (j % 24) / 8;
    hh = (j % 8) / 2;
    p = (mode != 0) ? seq(f * 12 + ln * 4 + hh) : 16'hA5C3;
`ifdef OV7670_TX_TESTPATTERN_EN
    p = pat(hh, ln);
`endif
    return (j % 2 != 0) ? p[7:0] : p[15:8];
  endfunction

  always @(negedge i_clk) begin
    cyc++;
    if (o_frame_done) done_cyc.push_back(cyc);
    if (o_VS && !prev_vs) vs_rise_cyc.push_back(cyc);
    if (o_PCLK && !prev_pclk) begin
      if (o_VS) vlen++;
      else if (vlen != 0) begin
        vs_len.push_back(vlen);
        vlen = 0;
      end
      if (o_HS) begin
        hlen++;
        bytes.push_back(o_DATA);
      end else begin
        if (hlen != 0) begin
          href_len.push_back(hlen);
          hlen = 0;
        end
        if (o_DATA != '0) blank_bad++;
      end
    end
    prev_vs   = o_VS;
    prev_pclk = o_PCLK;
  end

  // pixel source answering o_pix_req
  initial forever begin
    @(negedge i_clk);
    if (o_pix_req === 1'b1) begin
      req_cnt++;
      i_pixel = (drv_mode != 0) ? seq(drv_k) : 16'hA5C3;
      drv_k++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #2;
  endtask

  task automatic clear_mon();
    vs_rise_cyc.delete();
    vs_len.delete();
    href_len.delete();
    done_cyc.delete();
    bytes.delete();
    vlen = 0;
    hlen = 0;
    blank_bad = 0;
    req_cnt = 0;
    drv_k = 0;
  endtask

  function automatic logic [31:0] outs();
    return 32'({o_PCLK, o_VS, o_HS, o_busy,
                o_frame_done, o_pix_req, o_DATA});
  endfunction

  task automatic pulse_start();
    i_start = 1'b1;
    step(1);
    i_start = 1'b0;
  endtask

  task automatic wait_vs(input int n, input int lim, input string tag);
    int t = 0;
    while (vs_rise_cyc.size() < n && t < lim) begin
      step(1);
      t++;
    end
    chk(tag, 32'(vs_rise_cyc.size() >= n), 32'd1);
  endtask

  task automatic wait_done(input int n, input int lim, input string tag);
    int t = 0;
    while (done_cyc.size() < n && t < lim) begin
      step(1);
      t++;
    end
    chk(tag, 32'(done_cyc.size() >= n), 32'd1);
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    // reset
    step(3);
    chk("reset_outs", outs(), 32'd0);
    i_n_reset = 1'b1;
    step(1);
    chk("pclk_low_after_rel", 32'(o_PCLK), 32'd0);
    step(1);
    chk("pclk_first_rise", 32'(o_PCLK), 32'd1);
    step(20);
    chk("idle_no_busy", 32'(o_busy), 32'd0);
    chk("idle_no_vs", 32'(vs_rise_cyc.size()), 32'd0);

    // single frame, start while busy must be ignored
    clear_mon();
    drv_mode = 0;
    i_continuous = 1'b0;
    pulse_start();
    wait_vs(1, 20, "vs_rise_timeout");
    chk("busy_in_frame", 32'(o_busy), 32'd1);
    step(100);
    pulse_start();
    wait_done(1, 400, "done_timeout");
    step(300);
    chk("sf_vs_count", 32'(vs_rise_cyc.size()), 32'd1);
    chk("sf_vs_len", 32'(qget(vs_len, 0)), 32'd12);
    chk("sf_href_count", 32'(href_len.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("sf_href_len%0d", i),
          32'(qget(href_len, i)), 32'd8);
    chk("sf_done_pulses", 32'(done_cyc.size()), 32'd1);
    chk("sf_done_delay",
        32'(qget(done_cyc, 0) - qget(vs_rise_cyc, 0)), 32'd288);
    chk("sf_busy_after", 32'(o_busy), 32'd0);
    chk("sf_blank_zero", 32'(blank_bad), 32'd0);
    chk("sf_req_count", 32'(req_cnt), 32'(REQS));
    chk("sf_byte_count", 32'(bytes.size()), 32'd24);
    for (int j = 0; j < 24; j++)
      chk($sformatf("sf_byte%0d", j),
          32'((j < bytes.size()) ? bytes[j] : 8'hxx),
          32'(exp_b(0, j)));

    // continuous stream, dropped during frame 2
    clear_mon();
    drv_mode = 1;
    i_continuous = 1'b1;
    pulse_start();
    wait_vs(2, 400, "cont_vs2_timeout");
    chk("cont_period",
        32'(qget(vs_rise_cyc, 1) - qget(vs_rise_cyc, 0)), 32'd288);
    chk("cont_done_at_vs2",
        32'(qget(done_cyc, 0)), 32'(qget(vs_rise_cyc, 1)));
    step(40);
    i_continuous = 1'b0;
    wait_done(2, 400, "cont_done2_timeout");
    step(300);
    chk("cont_vs_count", 32'(vs_rise_cyc.size()), 32'd2);
    chk("cont_done_pulses", 32'(done_cyc.size()), 32'd2);
    chk("cont_busy_after", 32'(o_busy), 32'd0);
    chk("cont_href_count", 32'(href_len.size()), 32'd6);
    chk("cont_req_count", 32'(req_cnt), 32'(2 * REQS));
    chk("cont_blank_zero", 32'(blank_bad), 32'd0);
    chk("cont_byte_count", 32'(bytes.size()), 32'd48);
    for (int j = 0; j < 48; j++)
      chk($sformatf("cont_byte%0d", j),
          32'((j < bytes.size()) ? bytes[j] : 8'hxx),
          32'(exp_b(1, j)));

    // reset in the middle of an active line
    clear_mon();
    pulse_start();
    begin
      int t = 0;
      while (o_HS !== 1'b1 && t < 200) begin
        step(1);
        t++;
      end
      chk("hs_timeout", 32'(o_HS), 32'd1);
    end
    step(3);
    i_n_reset = 1'b0;
    #1;
    chk("async_reset_outs", outs(), 32'd0);
    step(2);
    i_n_reset = 1'b1;
    clear_mon();
    step(1);
    chk("pclk_restart_low", 32'(o_PCLK), 32'd0);
    step(400);
    chk("no_frame_after_rst", 32'(vs_rise_cyc.size()), 32'd0);
    chk("no_busy_after_rst", 32'(o_busy), 32'd0);
    pulse_start();
    wait_done(1, 400, "post_rst_done_timeout");
    chk("post_rst_bytes", 32'(bytes.size()), 32'd24);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
